// File: rtl/spi_sclk_engine.sv
// spi_sclk_engine: SCLK generator for all CPOL/CPHA modes with per-bit shift/sample strobes and frame done/abort pulses.
// Defining SPI_SCLK_INTERFRAME_GAP_EN adds gap_hp and an idle GAP state before done.
module spi_sclk_engine #(
  parameter int PRE_W  = 3,
  parameter int SPR_W  = 3,
  parameter int DIV_W  = 12,
  parameter int DATA_W = 8
) (
  input  logic             Pclk,
  input  logic             Presetn,
  input  logic             enable,
  input  logic             start,
  input  logic             cpol,
  input  logic             cpha,
  input  logic [PRE_W-1:0] sppr,
  input  logic [SPR_W-1:0] spr,
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
  input  logic [3:0]       gap_hp,
`endif
  output logic             sclk,
  output logic             busy,
  output logic             shift_stb,
  output logic             sample_stb,
  output logic             done,
  output logic             aborted,
  output logic [DIV_W-1:0] divisor
);
  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DATA_W);
  localparam logic [EW-1:0] E1 = EW'(1);
  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
  localparam logic [DIV_W-1:0] TWO = DIV_W'(2);
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  logic [3:0] gap_q, gap_left;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
  state_t state;
  logic [DIV_W-1:0] div_q, count;
  logic [EW-1:0] edge_cnt, nxt_edge;
  logic cpha_q, sclk_q, last_div, pre_div, lead, shift_hit, sample_hit;
  assign divisor = (DIV_W'(sppr) + ONE) << (DIV_W'(spr) + ONE);
  assign last_div = count == div_q - ONE;
  assign pre_div = count == div_q - TWO;
  assign nxt_edge = edge_cnt + E1;
  assign lead = nxt_edge[0];
  // the final trailing edge of a cpha=0 frame has no next bit to shift
  assign shift_hit = cpha_q ? lead : !lead && nxt_edge != LAST;
  assign sample_hit = cpha_q ? !lead : lead;
  assign sclk = state == IDLE ? cpol : sclk_q;
  always_ff @(posedge Pclk or negedge Presetn) begin
    if (!Presetn) begin
      state <= IDLE;
      busy <= 1'b0;
      shift_stb <= 1'b0;
      sample_stb <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      count <= '0;
      edge_cnt <= '0;
      div_q <= TWO;
      cpha_q <= 1'b0;
      sclk_q <= 1'b0;
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
      gap_q <= '0;
      gap_left <= '0;
`endif
    end else begin
      shift_stb <= 1'b0;
      sample_stb <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
      if (state == IDLE) begin
        count <= '0;
        edge_cnt <= '0;
        if (start && enable && !done) begin
          state <= RUN;
          busy <= 1'b1;
          div_q <= divisor;
          sclk_q <= cpol;
          cpha_q <= cpha;
          shift_stb <= !cpha;
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
          gap_q <= gap_hp;
`endif
        end
      end else if (!enable) begin
        state <= IDLE;
        busy <= 1'b0;
        aborted <= 1'b1;
        count <= '0;
        edge_cnt <= '0;
      end else begin
        count <= last_div ? '0 : count + ONE;
        if (state == RUN) begin
          shift_stb <= pre_div && shift_hit;
          sample_stb <= last_div && sample_hit;
          if (last_div) begin
            sclk_q <= !sclk_q;
            edge_cnt <= nxt_edge;
            if (nxt_edge == LAST) begin
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
              if (gap_q != 4'd0) begin
                state <= GAP;
                gap_left <= gap_q;
              end else begin
                state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
              end
`else
              state <= IDLE;
              busy <= 1'b0;
              done <= 1'b1;
`endif
            end
          end
        end
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
        else if (last_div) begin
          gap_left <= gap_left - 4'd1;
          if (gap_left == 4'd1) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
`endif
      end
    end
  end
endmodule

// File: tb/tb_spi_sclk_engine.sv
// tb_spi_sclk_engine: directed and random frames checked cycle by cycle against an arithmetic frame model.
module tb_spi_sclk_engine;
  logic Pclk = 1'b0, Presetn = 1'b0, enable = 1'b0, start = 1'b0, cpol = 1'b1, cpha = 1'b0;
  logic [2:0] sppr = '0, spr = '0;
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
  logic [3:0] gap_hp = '0;
`endif
  logic sclk, busy, shift_stb, sample_stb, done, aborted;
  logic [11:0] divisor;
  int total = 0, bad = 0;
  always #5 Pclk = ~Pclk;
  spi_sclk_engine dut (
    .Pclk(Pclk), .Presetn(Presetn), .enable(enable), .start(start), .cpol(cpol), .cpha(cpha),
    .sppr(sppr), .spr(spr),
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
    .gap_hp(gap_hp),
`endif
    .sclk(sclk), .busy(busy), .shift_stb(shift_stb), .sample_stb(sample_stb),
    .done(done), .aborted(aborted), .divisor(divisor)
  );
  function automatic int divf(input int p, input int s);
    return (p + 1) * (2 ** (s + 1));
  endfunction
  task automatic chk(input string tag, input int t, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d got=%0h exp=%0h", tag, t, obs, exp);
    end
  endtask
  // t=0 is the first busy cycle; edge k becomes visible at t=k*d, the frame ends at 16*d plus g*d gap
  task automatic frame(input int d, input bit pol, input bit pha, input int g,
                       input int abort_at, input int cfg_at, input bit b2b);
    int dt, tend, kk;
    bit ab;
    logic e_busy, e_sclk, e_sh, e_sa, e_done, e_ab;
    dt = 16 * d + g * d;
    ab = abort_at >= 0;
    tend = ab ? abort_at + 4 : dt + 1;
    start = 1'b1;
    @(negedge Pclk);
    for (int t = 0; t <= tend; t++) begin
      if (t > 0) @(negedge Pclk);
      e_busy = 0; e_sclk = cpol; e_sh = 0; e_sa = 0; e_done = 0; e_ab = 0;
      if (ab && t > abort_at) e_ab = (t == abort_at + 1);
      else begin
        e_busy = t < dt;
        e_done = t == dt;
        if (t < 16 * d) e_sclk = pol ^ (((t / d) % 2) != 0);
        else if (t < dt) e_sclk = pol;
        if (t == 0 && !pha) e_sh = 1;
        if ((t + 1) % d == 0 && (t + 1) / d <= 16) begin
          kk = (t + 1) / d;
          e_sh = pha ? (kk % 2 == 1) : (kk % 2 == 0 && kk != 16);
        end
        if (t > 0 && t % d == 0 && t / d <= 16) begin
          kk = t / d;
          e_sa = pha ? (kk % 2 == 0) : (kk % 2 == 1);
        end
      end
      chk("busy", t, busy, e_busy);
      chk("sclk", t, sclk, e_sclk);
      chk("shift_stb", t, shift_stb, e_sh);
      chk("sample_stb", t, sample_stb, e_sa);
      chk("done", t, done, e_done);
      chk("aborted", t, aborted, e_ab);
      chk("divisor", t, divisor, divf(int'(sppr), int'(spr)));
      start = (t == 3) || (b2b && t >= dt);
      if (t == abort_at) enable = 1'b0;
      if (t == cfg_at) begin
        sppr = 3'($urandom_range(0, 3));
        spr = 3'($urandom_range(0, 2));
        cpha = ~cpha;
      end
    end
    enable = 1'b1;
  endtask
  initial begin
    int d, a;
    repeat (3) @(negedge Pclk);
    chk("rst_sclk", 0, sclk, 1);
    chk("rst_busy", 0, busy, 0);
    chk("rst_shift", 0, shift_stb, 0);
    chk("rst_sample", 0, sample_stb, 0);
    chk("rst_done", 0, done, 0);
    chk("rst_aborted", 0, aborted, 0);
    chk("rst_divisor", 0, divisor, 2);
    Presetn = 1'b1;
    cpol = 1'b0;
    @(negedge Pclk);
    chk("idle_sclk", 0, sclk, 0);
    start = 1'b1;
    @(negedge Pclk);
    start = 1'b0;
    chk("dis_start_busy", 0, busy, 0);
    chk("dis_start_shift", 0, shift_stb, 0);
    @(negedge Pclk);
    chk("dis_start_busy2", 1, busy, 0);
    enable = 1'b1;
    frame(2, 0, 0, 0, -1, -1, 0);
    sppr = 3'd2; spr = 3'd1;
    cpol = 1'b0; cpha = 1'b1; frame(12, 0, 1, 0, -1, -1, 0);
    cpol = 1'b1; cpha = 1'b0; frame(12, 1, 0, 0, -1, -1, 0);
    cpol = 1'b1; cpha = 1'b1; frame(12, 1, 1, 0, -1, -1, 0);
    cpol = 1'b0; cpha = 1'b0; frame(12, 0, 0, 0, 60, -1, 0);
    frame(12, 0, 0, 0, -1, 7, 0);
    d = divf(int'(sppr), int'(spr));
    frame(d, 0, cpha, 0, -1, -1, 0);
    sppr = 3'd1; spr = 3'd0; cpha = 1'b1;
    frame(4, 0, 1, 0, -1, -1, 1);
    frame(4, 0, 1, 0, -1, -1, 0);
`ifdef SPI_SCLK_INTERFRAME_GAP_EN
    gap_hp = 4'd3; cpol = 1'b1; cpha = 1'b0;
    frame(4, 1, 0, 3, -1, -1, 0);
    frame(4, 1, 0, 3, 69, -1, 0);
    gap_hp = 4'd0;
`endif
    for (int i = 0; i < 6; i++) begin
      sppr = 3'($urandom_range(0, 3));
      spr = 3'($urandom_range(0, 2));
      cpol = 1'($urandom_range(0, 1));
      cpha = 1'($urandom_range(0, 1));
      d = divf(int'(sppr), int'(spr));
      a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 16 * d - 1)) : -1;
      frame(d, cpol, cpha, 0, a, -1, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
